// File: rtl/alu_pkg.sv
// Shared opcode encodings, operation classes and writeback tag type for the
// alu_issue_wb issue/writeback controller.
package alu_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_AND  = 5'b01001;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_NEG  = 5'b10000;
  localparam logic [4:0] OP_NOT  = 5'b10001;
  localparam logic [4:0] OP_SHRA = 5'b10101;

  // Width of the destination index carried in a tag (log2 of 16 registers).
  localparam int unsigned TAG_RD_W = 4;

  typedef enum logic [1:0] {
    CLS_NONE = 2'd0,
    CLS_RF   = 2'd1,
    CLS_HL   = 2'd2
  } op_class_e;

  typedef struct packed {
    logic                v;
    op_class_e           cls;
    logic [TAG_RD_W-1:0] rd;
  } tag_t;

  function automatic op_class_e op_class(input logic [4:0] opcode);
    op_class_e c;
    case (opcode)
      OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROL,
      OP_AND, OP_OR, OP_NEG, OP_NOT, OP_SHRA: c = CLS_RF;
      OP_MUL, OP_DIV:                         c = CLS_HL;
      default:                                c = CLS_NONE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_tag_pipe.sv
// Delay line of writeback tags, DEPTH stages deep, matched to the ALU latency.
module alu_tag_pipe
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 3
) (
  input  logic clk_i,
  input  logic clear_i,
  input  tag_t tag_i,
  output tag_t tag_o
);

  tag_t stage_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= tag_i;
      for (int unsigned i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/alu_issue_wb.sv
// Issue/writeback controller around the 3-stage ALU: scoreboarded issue,
// tag delay line, RF or HI/LO writeback. Optional perf counters: ALU_ISSUE_PERF_EN.
module alu_issue_wb
  import alu_pkg::*;
#(
  parameter  int unsigned ALU_LATENCY = 3,
  parameter  int unsigned NUM_REGS    = 16,
  localparam int unsigned RW          = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                clear,
  input  logic                issue_valid,
  output logic                issue_ready,
  input  logic [4:0]          issue_opcode,
  input  logic [RW-1:0]       issue_rd,
  input  logic [RW-1:0]       issue_rs_a,
  input  logic [RW-1:0]       issue_rs_b,
  output logic [4:0]          alu_opcode,
  input  logic [63:0]         alu_result,
  output logic                rf_we,
  output logic [RW-1:0]       rf_waddr,
  output logic [31:0]         rf_wdata,
  output logic [31:0]         hi_out,
  output logic [31:0]         lo_out,
  output logic [NUM_REGS-1:0] busy,
  output logic                hilo_busy
`ifdef ALU_ISSUE_PERF_EN
  ,
  output logic [31:0]         perf_issued,
  output logic [31:0]         perf_stall
`endif
);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic                hilo_q, hilo_d;
  logic                rf_we_q, rf_we_d;
  logic [RW-1:0]       rf_waddr_q, rf_waddr_d;
  logic [31:0]         rf_wdata_q, rf_wdata_d;
  logic [31:0]         hi_q, hi_d, lo_q, lo_d;
  op_class_e           cls;
  logic                fire;
  tag_t                tag_in, tag_ret;

  assign cls         = op_class(issue_opcode);
  assign issue_ready = !clear && !busy_q[issue_rs_a] && !busy_q[issue_rs_b] &&
                       !busy_q[issue_rd] && !((cls == CLS_HL) && hilo_q);
  assign fire        = issue_valid && issue_ready;
  assign alu_opcode  = fire ? issue_opcode : '0;

  always_comb begin
    tag_in = '0;
    if (fire) begin
      tag_in.v   = 1'b1;
      tag_in.cls = cls;
      tag_in.rd  = TAG_RD_W'(issue_rd);
    end
  end

  alu_tag_pipe #(.DEPTH(ALU_LATENCY)) u_tag_pipe (
    .clk_i   (clk),
    .clear_i (clear),
    .tag_i   (tag_in),
    .tag_o   (tag_ret)
  );

  // Retire clears before issue sets, so a same-cycle set on a bit wins.
  always_comb begin
    busy_d     = busy_q;
    hilo_d     = hilo_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    if (tag_ret.v) begin
      case (tag_ret.cls)
        CLS_RF: begin
          rf_we_d                  = 1'b1;
          rf_waddr_d               = RW'(tag_ret.rd);
          rf_wdata_d               = alu_result[31:0];
          busy_d[RW'(tag_ret.rd)]  = 1'b0;
        end
        CLS_HL: begin
          hi_d   = alu_result[63:32];
          lo_d   = alu_result[31:0];
          hilo_d = 1'b0;
        end
        default: ;
      endcase
    end
    if (fire) begin
      case (cls)
        CLS_RF:  busy_d[issue_rd] = 1'b1;
        CLS_HL:  hilo_d = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      busy_q     <= '0;
      hilo_q     <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      busy_q     <= busy_d;
      hilo_q     <= hilo_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign busy      = busy_q;
  assign hilo_busy = hilo_q;
  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign hi_out    = hi_q;
  assign lo_out    = lo_q;

`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] perf_issued_q, perf_stall_q;

  always_ff @(posedge clk) begin
    if (clear) begin
      perf_issued_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      if (fire)                        perf_issued_q <= perf_issued_q + 32'd1;
      if (issue_valid && !issue_ready) perf_stall_q  <= perf_stall_q + 32'd1;
    end
  end

  assign perf_issued = perf_issued_q;
  assign perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_alu_issue_wb.sv
// Bench for alu_issue_wb: ALU stand-in, in-flight-list reference model,
// per-cycle compare plus pinned literal expectations.
module tb_alu_issue_wb;

  logic        clk = 1'b0;
  logic        clear;
  logic        issue_valid;
  logic        issue_ready;
  logic [4:0]  issue_opcode;
  logic [3:0]  issue_rd, issue_rs_a, issue_rs_b;
  logic [4:0]  alu_opcode;
  logic [63:0] alu_result;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [31:0] rf_wdata, hi_out, lo_out;
  logic [15:0] busy;
  logic        hilo_busy;
`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] perf_issued, perf_stall;
`endif

  alu_issue_wb #(.ALU_LATENCY(3), .NUM_REGS(16)) dut (
    .clk          (clk),
    .clear        (clear),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .issue_opcode (issue_opcode),
    .issue_rd     (issue_rd),
    .issue_rs_a   (issue_rs_a),
    .issue_rs_b   (issue_rs_b),
    .alu_opcode   (alu_opcode),
    .alu_result   (alu_result),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .hi_out       (hi_out),
    .lo_out       (lo_out),
    .busy         (busy),
    .hilo_busy    (hilo_busy)
`ifdef ALU_ISSUE_PERF_EN
    ,
    .perf_issued  (perf_issued),
    .perf_stall   (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  // ALU stand-in: result for a sampled opcode appears after the third edge.
  logic [63:0] plan, plan_s, s0, s1, s2;
  logic [4:0]  op_s;
  assign alu_result = s2;
  always @(negedge clk) begin
    op_s   <= alu_opcode;
    plan_s <= plan;
  end
  always @(posedge clk) begin
    if (clear) begin
      s0 <= '0; s1 <= '0; s2 <= '0;
    end else begin
      s2 <= s1;
      s1 <= s0;
      s0 <= (op_s != 5'd0) ? plan_s : 64'd0;
    end
  end

  // Reference model: list of in-flight ops with the edge number they retire on.
  typedef struct {int cls; int rd; logic [63:0] data; int due;} fl_t;
  fl_t         q[$];
  int          cyc = 0;
  bit          armed = 0;
  logic        m_we;
  logic [3:0]  m_waddr;
  logic [31:0] m_wdata, m_hi, m_lo, m_iss, m_stl;

  function automatic int cls_of(input logic [4:0] op);
    case (op)
      5'd3, 5'd4, 5'd5, 5'd6, 5'd8, 5'd9, 5'd10, 5'd16, 5'd17, 5'd21: return 1;
      5'd14, 5'd15: return 2;
      default: return 0;
    endcase
  endfunction

  function automatic logic [15:0] m_busy();
    logic [15:0] b = '0;
    foreach (q[i]) if (q[i].cls == 1) b[q[i].rd] = 1'b1;
    return b;
  endfunction

  function automatic bit m_hilo();
    foreach (q[i]) if (q[i].cls == 2) return 1;
    return 0;
  endfunction

  function automatic bit m_ready();
    logic [15:0] b = m_busy();
    if (clear) return 0;
    if (b[issue_rs_a] || b[issue_rs_b] || b[issue_rd]) return 0;
    if (cls_of(issue_opcode) == 2 && m_hilo()) return 0;
    return 1;
  endfunction

  always @(posedge clk) begin
    bit f;
    f = issue_valid && m_ready();
    if (clear) begin
      q.delete();
      armed = 1;
      m_we = 0; m_waddr = '0; m_wdata = '0; m_hi = '0; m_lo = '0;
      m_iss = '0; m_stl = '0;
    end else begin
      if (f) m_iss = m_iss + 1;
      if (issue_valid && !f) m_stl = m_stl + 1;
      m_we = 0;
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].due == cyc) begin
          if (q[i].cls == 1) begin
            m_we = 1; m_waddr = 4'(q[i].rd); m_wdata = q[i].data[31:0];
          end else if (q[i].cls == 2) begin
            m_hi = q[i].data[63:32]; m_lo = q[i].data[31:0];
          end
          q.delete(i);
        end
      end
      if (f) q.push_back('{cls_of(issue_opcode), int'(issue_rd), plan, cyc + 3});
    end
    cyc = cyc + 1;
  end

  // Pinned literal expectations: {cycle, field, value}.
  typedef struct {int c; int k; logic [63:0] v;} pin_t;
  pin_t  pins[$];
  string pin_nm[9] = '{"rf_we", "rf_waddr", "rf_wdata", "busy", "hi_out",
                       "lo_out", "issue_ready", "alu_opcode", "hilo_busy"};

  function automatic logic [63:0] pin_act(input int k);
    case (k)
      0: return 64'(rf_we);
      1: return 64'(rf_waddr);
      2: return 64'(rf_wdata);
      3: return 64'(busy);
      4: return 64'(hi_out);
      5: return 64'(lo_out);
      6: return 64'(issue_ready);
      7: return 64'(alu_opcode);
      default: return 64'(hilo_busy);
    endcase
  endfunction

  int n_cmp = 0, n_bad = 0, timeouts = 0;
  bit done = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done) begin
      chk("issue_timeouts", 64'(timeouts), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
    end
    if (armed) begin
      chk("issue_ready", 64'(issue_ready), 64'(m_ready()));
      chk("alu_opcode", 64'(alu_opcode), (issue_valid && m_ready()) ? 64'(issue_opcode) : 64'd0);
      chk("rf_we", 64'(rf_we), 64'(m_we));
      chk("rf_waddr", 64'(rf_waddr), 64'(m_waddr));
      chk("rf_wdata", 64'(rf_wdata), 64'(m_wdata));
      chk("hi_out", 64'(hi_out), 64'(m_hi));
      chk("lo_out", 64'(lo_out), 64'(m_lo));
      chk("busy", 64'(busy), 64'(m_busy()));
      chk("hilo_busy", 64'(hilo_busy), 64'(m_hilo()));
`ifdef ALU_ISSUE_PERF_EN
      chk("perf_issued", 64'(perf_issued), 64'(m_iss));
      chk("perf_stall", 64'(perf_stall), 64'(m_stl));
`endif
    end
    foreach (pins[i])
      if (pins[i].c == cyc) chk({"pin_", pin_nm[pins[i].k]}, pin_act(pins[i].k), pins[i].v);
  end

  task automatic pin(input int c, input int k, input logic [63:0] v);
    pins.push_back('{c, k, v});
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Offer one instruction and hold it until accepted; returns just after the fire edge.
  task automatic issue(input logic [4:0] op, input logic [3:0] rd, input logic [3:0] ra,
                       input logic [3:0] rb, input logic [63:0] res);
    int n = 0;
    issue_valid = 1'b1; issue_opcode = op; issue_rd = rd;
    issue_rs_a = ra; issue_rs_b = rb; plan = res;
    while (n < 20) begin
      @(negedge clk);
      if (issue_ready) break;
      n++;
    end
    if (n >= 20) timeouts++;
    @(posedge clk); #1;
    issue_valid = 1'b0; plan = '0;
  endtask

  initial begin
    int f, g;
    clear = 1'b1; issue_valid = 1'b1; issue_opcode = 5'b00011;
    issue_rd = 4'd2; issue_rs_a = '0; issue_rs_b = '0; plan = '0;
    pin(1, 6, 0); pin(1, 7, 0); pin(1, 3, 0); pin(1, 0, 0); pin(2, 4, 0); pin(2, 5, 0);
    repeat (3) @(posedge clk);
    #1; clear = 1'b0; issue_valid = 1'b0;
    step();

    // ADD rd=3, result 7: write appears on the fourth edge counting the fire edge.
    issue(5'b00011, 4'd3, 4'd0, 4'd0, 64'h7);
    f = cyc;
    pin(f, 3, 16'h0008); pin(f + 1, 3, 16'h0008); pin(f + 2, 3, 16'h0008);
    pin(f + 3, 3, 16'h0000); pin(f + 3, 0, 1); pin(f + 3, 1, 3); pin(f + 3, 2, 7);
    pin(f + 4, 0, 0);
    repeat (6) step();

    // RAW: SUB reading r5 stalls three cycles, fires alongside the r5 write.
    issue(5'b00011, 4'd5, 4'd0, 4'd0, 64'h11);
    f = cyc;
    pin(f, 6, 0); pin(f, 7, 0); pin(f + 1, 6, 0); pin(f + 2, 6, 0);
    pin(f + 3, 6, 1); pin(f + 3, 7, 5'b00100); pin(f + 3, 0, 1); pin(f + 3, 1, 5);
    issue(5'b00100, 4'd7, 4'd5, 4'd1, 64'h22);
    repeat (6) step();

    // MUL to HI/LO, then DIV held off by hilo_busy until the MUL retires.
    issue(5'b01110, 4'd8, 4'd1, 4'd2, 64'h0000_0002_8000_0000);
    f = cyc;
    pin(f, 8, 1); pin(f, 6, 0); pin(f + 2, 6, 0); pin(f + 3, 6, 1); pin(f + 3, 8, 0);
    pin(f + 3, 4, 2); pin(f + 3, 5, 32'h8000_0000); pin(f + 3, 0, 0);
    issue(5'b01111, 4'd9, 4'd3, 4'd4, 64'h0000_0003_0000_0004);
    g = cyc;
    pin(g + 3, 4, 3); pin(g + 3, 5, 4); pin(g + 3, 0, 0);
    repeat (6) step();

    // Four independent ops back to back: four write pulses with no gaps.
    issue(5'b00011, 4'd1, 4'd0, 4'd0, 64'hA1);
    f = cyc;
    issue(5'b00110, 4'd2, 4'd0, 4'd0, 64'hB2);
    issue(5'b01010, 4'd3, 4'd0, 4'd0, 64'hC3);
    issue(5'b10001, 4'd4, 4'd0, 4'd0, 64'hFFFF_FFFF_DDDD_DDD4);
    for (int i = 0; i < 4; i++) begin
      pin(f + 3 + i, 0, 1); pin(f + 3 + i, 1, 64'(i + 1));
    end
    pin(f + 6, 2, 32'hDDDD_DDD4); pin(f + 7, 0, 0);
    repeat (6) step();

    // Undefined opcode: accepted, no scoreboard bit, no write of any kind.
    issue(5'b11111, 4'd11, 4'd0, 4'd0, 64'hDEAD_BEEF_1234_5678);
    f = cyc;
    pin(f, 3, 0); pin(f, 8, 0); pin(f + 3, 0, 0); pin(f + 3, 1, 4);
    pin(f + 3, 4, 3); pin(f + 3, 5, 4);
    repeat (6) step();

    // clear two cycles after ADD rd=6 fires drops it without a write.
    issue(5'b00011, 4'd6, 4'd0, 4'd0, 64'h66);
    f = cyc;
    step();
    clear = 1'b1;
    pin(f, 3, 16'h0040); pin(f + 1, 3, 16'h0040); pin(f + 1, 6, 0);
    pin(f + 2, 3, 0); pin(f + 2, 6, 1); pin(f + 3, 0, 0); pin(f + 4, 0, 0);
    step();
    clear = 1'b0;
    repeat (6) step();

    done = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
